// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, and single- or multi-step
// left/right shifts with serial fill or rotate, plus busy/done handshake.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             rot,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_LOAD = 2'b01;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] rem_q;
  logic             dir_q;   // 1 = shift right
  logic             rot_q;

  logic             shift_right_c;
  logic             shift_rot_c;
  logic             out_bit_c;
  logic             fill_c;
  logic [WIDTH-1:0] shifted_c;

  // One-bit shift datapath; direction/rot come live from the ports on the
  // accept edge and from the latched copies while a multi-step shift runs.
  always_comb begin
    shift_right_c = (state_q == SHIFT) ? dir_q : mode[0];
    shift_rot_c   = (state_q == SHIFT) ? rot_q : rot;
    out_bit_c     = shift_right_c ? q_q[0] : q_q[WIDTH-1];
    fill_c        = shift_rot_c ? out_bit_c : sin;
    shifted_c     = shift_right_c ? {fill_c, q_q[WIDTH-1:1]}
                                  : {q_q[WIDTH-2:0], fill_c};
  end

  // Control FSM and register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      // done is a single-cycle pulse even when enable drops.
      done_q <= 1'b0;
      if (enable) begin
        case (state_q)
          IDLE: begin
            if (mode == MODE_LOAD) begin
              q_q <= d;
            end else if (mode[1] && start) begin
              if (amount == '0) begin
                done_q <= 1'b1;
              end else begin
                q_q   <= shifted_c;
                sout_q <= out_bit_c;
                dir_q <= mode[0];
                rot_q <= rot;
                if (amount == CNT_W'(1)) begin
                  done_q <= 1'b1;
                end else begin
                  busy_q  <= 1'b1;
                  rem_q   <= amount - CNT_W'(1);
                  state_q <= SHIFT;
                end
              end
            end
          end
          SHIFT: begin
            q_q    <= shifted_c;
            sout_q <= out_bit_c;
            rem_q  <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: stimulus pushes expected completions into
// a queue; a negedge monitor pops and checks them whenever done pulses.
module tb_univ_shift_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             sout;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             rot;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .d(d),
    .sin(sin), .rot(rot), .start(start), .amount(amount),
    .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] eq, input logic es, input int ec);
    exp_t e;
    e.q = eq; e.sout = es; e.cyc = ec;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_q",    64'(q),    64'(e.q));
        check("done_sout", 64'(sout), 64'(e.sout));
        check("done_cyc",  64'(cyc),  64'(e.cyc));
        check("done_busy", 64'(busy), 64'(0));
      end
    end
  end

  initial begin
    int e0;
    reset = 1'b1; enable = 1'bx; mode = 2'bxx; d = 'x; start = 1'bx;
    sin = 1'b0; rot = 1'b0; amount = '0;
    tick(); tick();
    check("rst_q", 64'(q), 64'h00);
    check("rst_sout", 64'(sout), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));

    // Load, hold, and load blocked by enable=0.
    reset = 1'b0; enable = 1'b1; mode = 2'b01; d = 8'hA5; start = 1'b0;
    tick();
    check("load_q", 64'(q), 64'hA5);
    mode = 2'b00;
    repeat (5) tick();
    check("hold_q", 64'(q), 64'hA5);
    enable = 1'b0; mode = 2'b01; d = 8'h3C;
    tick();
    check("frozen_load_q", 64'(q), 64'hA5);

    // Shift left 3, serial fill 1: A5 -> 4B -> 97 -> 2F.
    enable = 1'b1; mode = 2'b10; start = 1'b1; amount = 4'd3; rot = 1'b0; sin = 1'b1;
    e0 = cyc + 1;
    push(8'h2F, 1'b1, e0 + 2);
    tick();
    start = 1'b0;
    check("shl_busy1", 64'(busy), 64'(1));
    check("shl_q1", 64'(q), 64'h4B);
    tick();
    check("shl_busy2", 64'(busy), 64'(1));
    tick();
    check("shl_q3", 64'(q), 64'h2F);
    check("shl_busy3", 64'(busy), 64'(0));
    tick();
    check("shl_done_clear", 64'(done), 64'(0));

    // Rotate right 4 with a 2-cycle stall; mid-run port changes must be ignored.
    mode = 2'b01; d = 8'hA5;
    tick();
    mode = 2'b11; rot = 1'b1; amount = 4'd4; start = 1'b1;
    e0 = cyc + 1;
    push(8'h5A, 1'b0, e0 + 5);
    tick();
    start = 1'b0; rot = 1'b0; sin = 1'b1; mode = 2'b01; d = 8'hFF;
    tick();
    check("ror_q2", 64'(q), 64'h69);
    enable = 1'b0;
    tick();
    check("stall_q", 64'(q), 64'h69);
    check("stall_busy", 64'(busy), 64'(1));
    tick();
    check("stall_q2", 64'(q), 64'h69);
    enable = 1'b1;
    tick();
    check("ror_q3", 64'(q), 64'hB4);
    tick();
    check("ror_q4", 64'(q), 64'h5A);
    mode = 2'b00;
    tick();

    // Zero-amount start: done pulse, q unchanged.
    mode = 2'b10; start = 1'b1; amount = 4'd0;
    e0 = cyc + 1;
    push(8'h5A, 1'b0, e0);
    tick();
    start = 1'b0;
    check("zero_q", 64'(q), 64'h5A);
    tick();
    check("zero_done_clear", 64'(done), 64'(0));

    // Start held while busy is dropped: 5A << 2 fill 0 -> B4 -> 68.
    mode = 2'b10; rot = 1'b0; sin = 1'b0; amount = 4'd2; start = 1'b1;
    e0 = cyc + 1;
    push(8'h68, 1'b1, e0 + 1);
    tick();
    amount = 4'd7;
    tick();
    start = 1'b0;
    tick();
    check("drop_busy", 64'(busy), 64'(0));
    check("drop_q", 64'(q), 64'h68);

    // Single shift right fill 1: 68 -> B4, never busy.
    mode = 2'b11; sin = 1'b1; amount = 4'd1; start = 1'b1;
    e0 = cyc + 1;
    push(8'hB4, 1'b0, e0);
    tick();
    start = 1'b0;
    check("one_busy", 64'(busy), 64'(0));
    tick();

    // Amount larger than WIDTH: rotate left 10 of B4 -> D2.
    mode = 2'b10; rot = 1'b1; amount = 4'd10; start = 1'b1;
    e0 = cyc + 1;
    push(8'hD2, 1'b0, e0 + 9);
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
    check("long_timeout", 64'(busy), 64'(0));
    tick();

    // Reset mid-shift aborts with no done pulse.
    mode = 2'b11; rot = 1'b0; sin = 1'b0; amount = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_q", 64'(q), 64'h00);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    reset = 1'b0;
    tick();
    check("abort_done_next", 64'(done), 64'(0));
    repeat (4) tick();
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 2..64.
REQ-002 Parameter CNT_W, default 4, width of the shift-amount input.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset; synchronous, active-high.
REQ-005 Port enable  input  1  clock enable; 0 = all state frozen (reset excepted).
REQ-006 Port mode  input  2  operation select: 00 hold, 01 parallel load, 10 shift left, 11 shift right.
REQ-007 Port d  input  WIDTH  parallel load data.
REQ-008 Port sin  input  1  serial fill bit for shifts when rot=0.
REQ-009 Port rot  input  1  1 = rotate (shifted-out bit refills), 0 = serial fill from sin.
REQ-010 Port start  input  1  request multi-step shift of amount positions (mode 10/11 only).
REQ-011 Port amount  input  CNT_W  number of single-bit shifts requested.
REQ-012 Port q  output  WIDTH  register contents.
REQ-013 Port sout  output  1  bit shifted out by the most recent shift.
REQ-014 Port busy  output  1  multi-step shift in progress.
REQ-015 Port done  output  1  one-cycle pulse on multi-step shift completion.

Function
REQ-016 Two states, IDLE and SHIFT, with an internal remaining-count register rem of width CNT_W.
REQ-017 IDLE, enable=1, mode=00 or (mode=1x, start=0): q holds; no state change.
REQ-018 IDLE, enable=1, mode=01: q <= d on that edge; start ignored; sout unchanged.
REQ-019 IDLE, enable=1, mode=1x, start=1, amount=0: q unchanged; done=1 for the next cycle; stay IDLE.
REQ-020 IDLE, enable=1, mode=1x, start=1, amount=N>=1: first shift on the accept edge; direction and rot latched; if N=1 done=1 next cycle and stay IDLE, else busy=1, rem<=N-1, go SHIFT.
REQ-021 Shift left: q <= {q[WIDTH-2:0], fill}, sout <= q[WIDTH-1]; shift right: q <= {fill, q[WIDTH-1:1]}, sout <= q[0].
REQ-022 fill = bit being shifted out when latched rot=1, else sin sampled on that edge (sin never latched).
REQ-023 SHIFT, enable=1: one shift per edge, rem decrements; edge where rem goes 1->0: busy<=0, done<=1, go IDLE.
REQ-024 SHIFT, enable=0: q, sout, rem, busy frozen; completion delayed cycle-for-cycle.
REQ-025 In SHIFT, mode, d, rot, start, amount ignored; start during busy is dropped, not queued.
REQ-026 N accepted shifts always complete in exactly N enabled edges; done asserted the cycle after the last.
REQ-027 done is high for exactly one cycle, then 0, independent of enable.
REQ-028 amount > WIDTH legal; shifts proceed literally (rotation wraps, serial fill fully replaces).

Reset
REQ-029 reset=1 at an edge, regardless of enable or state: q=0, sout=0, busy=0, done=0, rem=0, state IDLE.
REQ-030 Reset mid-operation aborts the shift; no done pulse is produced for the aborted operation.
REQ-031 X on d, mode, start or enable during reset does not propagate to any output.

Verification (WIDTH=8, CNT_W=4)
REQ-032 reset=1 two cycles, enable/d = X -> q=00, sout=0, busy=0, done=0.
REQ-033 enable=1, mode=01, d=A5 -> q=A5 after one edge; mode=00 five cycles -> q stays A5; enable=0 with mode=01, d=3C -> q stays A5.
REQ-034 q=A5, mode=10, start=1, amount=3, rot=0, sin=1 -> busy=1 after edges 1-2, q=2F after edge 3, sout=1, done=1 one cycle, busy=0.
REQ-035 q=A5, mode=11, rot=1, amount=4, enable=0 for 2 cycles after edge 2 -> q frozen during stall, q=5A, done after 6th edge from accept.
REQ-036 amount=0 start -> single done pulse, q unchanged; start pulse while busy -> ignored, shift count unaffected.
REQ-037 amount=5 shift, reset=1 after 2nd shift -> q=00, busy=0, done stays 0 next cycle.
